// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: constants, types and helpers shared by the fetch stage.
//   NOP        - canonical bubble instruction (addi x0, x0, 0)
//   FetchState - RUN: outstanding request is useful; DROP: it is stale
//   word_align - clears the byte-offset bits of an address
package fetch_stage_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } FetchState;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage : fetch_stage_pkg

// File: rtl/pc_src_pkg.sv
// pc_src: shared next-PC select encoding used by pipeline control and fetch.
//   PCSrc - PC4 (sequential), BRANCH (EX-resolved target), JUMP (ID-resolved target)
package pc_src;

  typedef enum logic [1:0] {
    PC4    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2
  } PCSrc;

endpackage : pc_src

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
// Ports:
//   i_clk, i_rst      clock and synchronous active-high reset
//   i_flush           force a bubble (highest priority, beats a hold)
//   i_w_en            write enable; 0 holds the current contents
//   i_fetch_ok        a usable instruction is presented this cycle
//   i_pc, i_instr     PC and instruction word to capture
//   o_pc, o_instr     registered contents
//   o_valid           contents are a real instruction, not a bubble
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_w_en,
  input  logic        i_fetch_ok,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  // Next-state selection: flush, then load, then bubble on a missing fetch, else hold.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (i_flush) begin
      pc_d    = 32'h0000_0000;
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (i_w_en && i_fetch_ok) begin
      pc_d    = i_pc;
      instr_d = i_instr;
      valid_d = 1'b1;
    end else if (i_w_en) begin
      // Decode is ready but fetch produced nothing: hand it a bubble.
      pc_d    = 32'h0000_0000;
      instr_d = NOP;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
    end
  end

  // IF/ID storage with synchronous reset to a bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q    <= 32'h0000_0000;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign o_pc    = pc_q;
  assign o_instr = instr_q;
  assign o_valid = valid_q;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage RISC-V pipeline.
// Owns the PC, issues requests on a variable-latency imem req/ack port and
// loads IF/ID. A redirect taken while a request is outstanding marks that
// request stale (DROP) so its data never reaches decode.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_pc_w_en, i_addr_sel        PC write enable and next-PC select
//   i_branch_target, i_jump_target redirect targets (bits [1:0] ignored)
//   i_flush_if_id, i_w_en_if_id  IF/ID flush and write enable
//   o_imem_req, o_imem_addr      fetch request and word-aligned address
//   i_imem_ack, i_imem_rdata     fetch completion and instruction word
//   o_if_id_pc/instr/valid       IF/ID contents
//   o_fetch_stall                no usable instruction this cycle
module fetch_stage
  import pc_src::*;
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pc_w_en,
  input  PCSrc        i_addr_sel,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_jump_target,
  input  logic        i_flush_if_id,
  input  logic        i_w_en_if_id,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_instr,
  output logic        o_if_id_valid,
  output logic        o_fetch_stall
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  FetchState   state_q, state_d;

  logic        fetch_ok_s;
  logic        redirect_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;

  // An ack is only usable for the current (non-stale) request; reset kills it.
  assign fetch_ok_s = (state_q == RUN) && i_imem_ack && !i_rst;
  assign redirect_s = i_pc_w_en && (i_addr_sel != PC4);
  assign pc_plus4_s = pc_q + 32'd4;

  // Redirect target selection, word-aligned.
  always_comb begin
    target_s = 32'h0000_0000;
    case (i_addr_sel)
      JUMP:    target_s = word_align(i_jump_target);
      BRANCH:  target_s = word_align(i_branch_target);
      default: target_s = word_align(i_branch_target);
    endcase
  end

  // Next PC / request address / FSM state.
  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    state_d    = state_q;
    case (state_q)
      RUN: begin
        if (redirect_s) begin
          pc_d = target_s;
          if (fetch_ok_s) begin
            req_addr_d = target_s;
          end else begin
            // The address must stay stable until the pending request acks,
            // so the target is remembered in pc and fetched afterwards.
            req_addr_d = req_addr_q;
            state_d    = DROP;
          end
        end else if (i_pc_w_en && fetch_ok_s) begin
          pc_d       = pc_plus4_s;
          req_addr_d = pc_plus4_s;
        end else begin
          pc_d       = pc_q;
          req_addr_d = req_addr_q;
        end
      end
      DROP: begin
        if (redirect_s) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
        if (i_imem_ack) begin
          // Stale data is discarded; start fetching the newest target.
          req_addr_d = pc_d;
          state_d    = RUN;
        end else begin
          req_addr_d = req_addr_q;
          state_d    = DROP;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // PC, request address and FSM state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q       <= word_align(RESET_PC);
      req_addr_q <= word_align(RESET_PC);
      state_q    <= RUN;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      state_q    <= state_d;
    end
  end

  assign o_imem_req    = !i_rst;
  assign o_imem_addr   = {req_addr_q[31:2], 2'b00};
  assign o_fetch_stall = !fetch_ok_s;

  if_id_reg u_if_id_reg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_flush    (i_flush_if_id),
    .i_w_en     (i_w_en_if_id),
    .i_fetch_ok (fetch_ok_s),
    .i_pc       (o_imem_addr),
    .i_instr    (i_imem_rdata),
    .o_pc       (o_if_id_pc),
    .o_instr    (o_if_id_instr),
    .o_valid    (o_if_id_valid)
  );

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage. Each step
// drives controls and the memory response, checks the combinational request
// outputs, pushes the expected IF/ID contents to a scoreboard and pops/compares
// them after the clock edge.
module tb_fetch_stage;
  import pc_src::*;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam int K_LOAD   = 0;
  localparam int K_BUBBLE = 1;
  localparam int K_HOLD   = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_pc_w_en = 1'b0;
  PCSrc        i_addr_sel = PC4;
  logic [31:0] i_branch_target = 32'h0;
  logic [31:0] i_jump_target = 32'h0;
  logic        i_flush_if_id = 1'b0;
  logic        i_w_en_if_id = 1'b0;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic [31:0] o_if_id_pc;
  logic [31:0] o_if_id_instr;
  logic        o_if_id_valid;
  logic        o_fetch_stall;

  int    total = 0;
  int    bad = 0;
  ifid_t sb[$];
  ifid_t model;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_pc_w_en       (i_pc_w_en),
    .i_addr_sel      (i_addr_sel),
    .i_branch_target (i_branch_target),
    .i_jump_target   (i_jump_target),
    .i_flush_if_id   (i_flush_if_id),
    .i_w_en_if_id    (i_w_en_if_id),
    .o_imem_req      (o_imem_req),
    .o_imem_addr     (o_imem_addr),
    .i_imem_ack      (i_imem_ack),
    .i_imem_rdata    (i_imem_rdata),
    .o_if_id_pc      (o_if_id_pc),
    .o_if_id_instr   (o_if_id_instr),
    .o_if_id_valid   (o_if_id_valid),
    .o_fetch_stall   (o_fetch_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock step. tgt goes to the selected target port; the other port
  // gets a different value so a wrong target selection is visible.
  task automatic step(input logic rst, input logic pcw, input PCSrc sel,
                      input logic [31:0] tgt, input logic flush, input logic wen,
                      input logic ack, input logic [31:0] exp_addr,
                      input logic exp_stall, input int kind);
    ifid_t e;
    @(negedge clk);
    i_rst           = rst;
    i_pc_w_en       = pcw;
    i_addr_sel      = sel;
    i_jump_target   = (sel == JUMP) ? tgt : (tgt ^ 32'h0000_1000);
    i_branch_target = (sel == JUMP) ? (tgt ^ 32'h0000_1000) : tgt;
    i_flush_if_id   = flush;
    i_w_en_if_id    = wen;
    i_imem_ack      = ack;
    // Memory model: the word at address A is A ^ KEY.
    i_imem_rdata    = ack ? (o_imem_addr ^ KEY) : 32'hDEAD_BEEF;
    #1;
    chk("imem_req", {31'h0, o_imem_req}, {31'h0, !rst});
    chk("fetch_stall", {31'h0, o_fetch_stall}, {31'h0, exp_stall});
    if (!rst) chk("imem_addr", o_imem_addr, exp_addr);
    if (kind == K_LOAD) begin
      model.pc    = exp_addr;
      model.instr = exp_addr ^ KEY;
      model.valid = 1'b1;
    end else if (kind == K_BUBBLE) begin
      model.pc    = 32'h0;
      model.instr = NOP;
      model.valid = 1'b0;
    end
    sb.push_back(model);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("ifid_pc", o_if_id_pc, e.pc);
    chk("ifid_instr", o_if_id_instr, e.instr);
    chk("ifid_valid", {31'h0, o_if_id_valid}, {31'h0, e.valid});
  endtask

  initial begin
    model = '{pc: 32'h0, instr: NOP, valid: 1'b0};
    // Reset: no request, stall asserted, IF/ID bubble.
    step(1'b1, 1'b0, PC4, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, K_BUBBLE);
    step(1'b1, 1'b0, PC4, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, K_BUBBLE);
    // Zero-wait sequential fetch.
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b1, RST_PC, 1'b0, K_LOAD);
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b1, 32'h4, 1'b0, K_LOAD);
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8, 1'b0, K_LOAD);
    // Two wait cycles at 0xC: address held, bubbles into IF/ID.
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b0, 32'hC, 1'b1, K_BUBBLE);
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b0, 32'hC, 1'b1, K_BUBBLE);
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b1, 32'hC, 1'b0, K_LOAD);
    // Branch to 0x100 with flush and same-cycle ack.
    step(1'b0, 1'b1, BRANCH, 32'h100, 1'b1, 1'b1, 1'b1, 32'h10, 1'b0, K_BUBBLE);
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, K_LOAD);
    // Jump to 0x40 while 0x104 is unacked: DROP, stale data discarded.
    step(1'b0, 1'b1, JUMP, 32'h40, 1'b0, 1'b1, 1'b0, 32'h104, 1'b1, K_BUBBLE);
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b0, 32'h104, 1'b1, K_BUBBLE);
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b1, 32'h104, 1'b1, K_BUBBLE);
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, K_LOAD);
    // Slip with ack: IF/ID unchanged, same address re-requested.
    step(1'b0, 1'b0, PC4, 32'h0, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0, K_HOLD);
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b1, 32'h44, 1'b0, K_LOAD);
    // Flush wins over hold.
    step(1'b0, 1'b0, PC4, 32'h0, 1'b1, 1'b0, 1'b0, 32'h48, 1'b1, K_BUBBLE);
    // Two redirects in DROP; latest target (low bits ignored) wins.
    step(1'b0, 1'b1, JUMP, 32'h80, 1'b0, 1'b1, 1'b0, 32'h48, 1'b1, K_BUBBLE);
    step(1'b0, 1'b1, BRANCH, 32'h203, 1'b0, 1'b1, 1'b1, 32'h48, 1'b1, K_BUBBLE);
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, K_LOAD);
    // Enter DROP, then reset: back to RUN at RESET_PC.
    step(1'b0, 1'b1, JUMP, 32'h300, 1'b0, 1'b1, 1'b0, 32'h204, 1'b1, K_BUBBLE);
    step(1'b1, 1'b0, PC4, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, K_BUBBLE);
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b1, RST_PC, 1'b0, K_LOAD);
    // PC4 wrap from 0xFFFF_FFFC.
    step(1'b0, 1'b1, JUMP, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 32'h4, 1'b0, K_LOAD);
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, K_LOAD);
    step(1'b0, 1'b1, PC4, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, K_LOAD);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_stage
